// File: rtl/updown_step_counter.sv
// updown_step_counter
//   Generic up/down counter with a runtime step, a runtime inclusive upper
//   limit, wrap-or-saturate mode, parallel load, and carry/terminal flags.
//
// Ports
//   clk      : clock, all state updates on the rising edge
//   rst      : synchronous reset, active-high (highest priority)
//   en       : count enable
//   down     : 0 = count up, 1 = count down
//   step     : increment/decrement magnitude
//   wrap     : 1 = modulo (limit+1) wrap, 0 = saturate at 0 / limit
//   limit    : inclusive upper bound of the count range [0, limit]
//   load     : parallel load strobe
//   load_val : value to load (clamped to limit)
//   out      : registered count
//   carry    : registered one-cycle pulse, set when an update wrapped or clamped
//   tc       : combinational terminal count for the current direction
module updown_step_counter #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              down,
  input  logic [STEP_W-1:0] step,
  input  logic              wrap,
  input  logic [WIDTH-1:0]  limit,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  out,
  output logic              carry,
  output logic              tc
);

  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;

  // All arithmetic is done in WIDTH+1 bits so that limit+1 (up to 2^WIDTH)
  // and out+s_eff (up to 2*limit+1) never overflow.
  logic [WIDTH:0] lim_p1;
  logic [WIDTH:0] step_ext;
  logic [WIDTH:0] s_eff;
  logic [WIDTH:0] out_ext;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] sum_wrapped;
  logic [WIDTH:0] diff_wrapped;

  always_comb begin
    lim_p1       = {1'b0, limit} + {{WIDTH{1'b0}}, 1'b1};
    step_ext     = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
    // A step larger than the range size is one full revolution at most.
    s_eff        = (step_ext > lim_p1) ? lim_p1 : step_ext;
    out_ext      = {1'b0, out_q};
    sum          = out_ext + s_eff;
    sum_wrapped  = sum - lim_p1;
    diff_wrapped = (out_ext + lim_p1) - s_eff;
  end

  always_comb begin
    out_d   = out_q;
    carry_d = 1'b0;
    if (out_q > limit) begin
      // Limit was lowered below the current count: pull the count back in.
      out_d = limit;
    end else if (load) begin
      out_d = (load_val > limit) ? limit : load_val;
    end else if (en) begin
      if (!down) begin
        if (sum > {1'b0, limit}) begin
          out_d   = wrap ? WIDTH'(sum_wrapped) : limit;
          carry_d = 1'b1;
        end else begin
          out_d = WIDTH'(sum);
        end
      end else begin
        if (out_ext >= s_eff) begin
          out_d = WIDTH'(out_ext - s_eff);
        end else begin
          out_d   = wrap ? WIDTH'(diff_wrapped) : '0;
          carry_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      carry_q <= carry_d;
    end
  end

  assign out   = out_q;
  assign carry = carry_q;
  assign tc    = (!down && (out_q == limit)) || (down && (out_q == '0));

endmodule
